arbitro_rr: RTL and testbench
=============================

Name: arbitro_rr

Overview:
- Parametrised successor to the 4x4 fixed-size arbiter.
- Moves words from NUM_IN input FIFOs to NUM_OUT output FIFOs. The destination is taken from a field of each head-of-queue word.
- Selects among eligible inputs by round-robin or fixed priority, with per-output back-pressure via almost_full.
- Sits between the input-FIFO bank and the output-FIFO bank of the router datapath.

Parameters:
NUM_IN, 4, number of input FIFOs (2..16)
NUM_OUT, 4, number of output FIFOs (power of 2, 2..16)
DATA_WIDTH, 12, word width
DEST_LSB, 8, bit position of destination field LSB in a word
DEST_WIDTH, 2, destination field width; must equal clog2(NUM_OUT)
MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
CNT_WIDTH, 8, width of optional per-output push counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
empty  in  NUM_IN  input FIFO empty flags
fifo_data  in  NUM_IN*DATA_WIDTH  show-ahead head words; input i at [i*DATA_WIDTH +: DATA_WIDTH]
almost_full  in  NUM_OUT  output FIFO almost-full flags
pop  out  NUM_IN  one-hot read strobe to input FIFOs
push  out  NUM_OUT  one-hot write strobe to output FIFOs
data_out  out  DATA_WIDTH  word written with push
grant_idx  out  clog2(NUM_IN)  index of input currently popped
idle  out  1  high when no transfer is issued this cycle
push_cnt  out  NUM_OUT*CNT_WIDTH  per-output push counters (see Optional Feature)

Behaviour:
- Reset (reset=0, async): pop=0, push=0, data_out=0, grant_idx=0, idle=1, RR pointer=0, counters=0. State=IDLE.
- Eligibility, per cycle: input i is eligible iff all of:
  - empty[i]=0;
  - almost_full[dest_i]=0, where dest_i = fifo_data[i][DEST_LSB +: DEST_WIDTH];
  - pop[i] is not currently high. Its head is stale until the FIFO updates, so it is masked for one cycle.
- Selection, combinational from eligible set:
  - MODE 0: first eligible index strictly after the last granted index, wrapping from NUM_IN-1 to 0.
  - MODE 1: lowest eligible index.
- Outputs, all registered (1-cycle latency from decision): on the edge after input g is selected with destination d:
  - pop[g]=1, push[d]=1;
  - data_out = fifo_data[g] as sampled at decision;
  - grant_idx = g; idle=0.
  - All strobes last exactly one cycle.
- At most one pop and one push per cycle. Back-to-back transfers from different inputs are allowed every cycle. The same input transfers at most every other cycle.
- RR pointer updates to g only on a grant. It holds when nothing is eligible.
- FSM:
  - IDLE: no eligible input -> stay; else -> XFER.
  - XFER: strobes active; eligible exists -> XFER; else -> IDLE.
  - idle=1 exactly in IDLE.
- almost_full is trusted to leave ≥1 slot. A push issued while almost_full rises on the same edge is still completed.
- Boundaries:
  - All empty -> IDLE, no strobes.
  - All destinations almost_full -> no strobes, even with data present.
  - Several inputs target the same destination -> one per cycle in arbitration order.
  - Reset asserted mid-transfer -> strobes drop immediately (async). No word is half-written because push and pop are single-cycle.
- Parameter check: DEST_WIDTH ≠ clog2(NUM_OUT) -> elaboration $error.

Optional Feature:
- Macro ARBITRO_PUSH_CNT_EN.
- Defined: push_cnt[d] increments on every cycle push[d]=1, wraps at 2^CNT_WIDTH, and clears on reset.
- Undefined: push_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package arbitro_pkg:
  - MODE_RR=0, MODE_PRIO=1 constants;
  - clog2 function;
  - dest-field extract function.
- Sub-module arbitro_pick: combinational NUM_IN-wide requester-to-one-hot picker with pointer and mode inputs. Instantiated once.

Test Plan:
- Reset with empty=4'b0000 and valid heads -> all outputs 0, idle=1. After release, the first grant is input 0 (pop=0001), with push per its dest.
- MODE 0, all four inputs non-empty, dests 0,1,2,3, no almost_full -> pops 0001,0010,0100,1000,0001 on consecutive cycles. Pushes are 0001,0010,0100,1000, and data_out matches each head.
- MODE 1, inputs 1 and 3 non-empty, 3 refilled continuously -> input 1 is granted every other cycle, with input 3 in the gaps. Input 1 is never starved by 3.
- Input 2 head dest=3, almost_full=4'b1000 -> no pop[2]. Other inputs proceed. Dropping almost_full[3] gives pop[2]/push[3] one cycle later.
- Assert reset low mid-burst -> pop/push go to 0 within the same cycle. After release, the RR pointer restarts at 0.
- With ARBITRO_PUSH_CNT_EN, 300 pushes to output 1 -> push_cnt[1]=44 (wrap at 256). Without the macro, push_cnt stays 0.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared constants and helpers for the arbitro_rr input-to-output FIFO arbiter.
package arbitro_pkg;

   localparam int unsigned MODE_RR        = 0;
   localparam int unsigned MODE_PRIO      = 1;
   localparam int unsigned MAX_WORD_WIDTH = 64;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned dest_field(input logic [MAX_WORD_WIDTH-1:0] word,
                                              input int unsigned lsb,
                                              input int unsigned width);
      logic [MAX_WORD_WIDTH-1:0] shifted;
      logic [31:0]               mask;
      shifted = word >> lsb;
      mask    = (32'd1 << width) - 32'd1;
      return shifted[31:0] & mask;
   endfunction

endpackage

// File: rtl/arbitro_pick.sv
// Combinational picker: one-hot grant of the first requester at or after `start`
// (round-robin) or the lowest requester (priority mode).
module arbitro_pick import arbitro_pkg::*; #(
   parameter int unsigned NumReq   = 4,
   parameter int unsigned IdxWidth = clog2(NumReq)
) (
   input  logic [NumReq-1:0]   req,
   input  logic [IdxWidth-1:0] start,
   input  logic                prio_mode,
   output logic [NumReq-1:0]   gnt,
   output logic [IdxWidth-1:0] gnt_idx,
   output logic                any
);

   logic [IdxWidth-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand = prio_mode ? IdxWidth'(k) : IdxWidth'((32'(start) + k) % NumReq);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/arbitro_rr.sv
// Arbiter moving head words from NUM_IN input FIFOs to NUM_OUT output FIFOs.
// Optional per-output push counters enabled by defining ARBITRO_PUSH_CNT_EN.
module arbitro_rr import arbitro_pkg::*; #(
   parameter int unsigned NUM_IN     = 4,
   parameter int unsigned NUM_OUT    = 4,
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned DEST_LSB   = 8,
   parameter int unsigned DEST_WIDTH = 2,
   parameter int unsigned MODE       = 0,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_IN-1:0]              empty,
   input  logic [NUM_IN*DATA_WIDTH-1:0]   fifo_data,
   input  logic [NUM_OUT-1:0]             almost_full,
   output logic [NUM_IN-1:0]              pop,
   output logic [NUM_OUT-1:0]             push,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic [clog2(NUM_IN)-1:0]       grant_idx,
   output logic                           idle,
   output logic [NUM_OUT*CNT_WIDTH-1:0]   push_cnt
);

   localparam int unsigned IdxW = clog2(NUM_IN);

   if (DEST_WIDTH != clog2(NUM_OUT)) begin : g_bad_dest
      $error("arbitro_rr: DEST_WIDTH must equal clog2(NUM_OUT)");
   end
   if (DATA_WIDTH > MAX_WORD_WIDTH || DEST_LSB + DEST_WIDTH > DATA_WIDTH) begin : g_bad_word
      $error("arbitro_rr: destination field does not fit in the word");
   end
   if (MODE != MODE_RR && MODE != MODE_PRIO) begin : g_bad_mode
      $error("arbitro_rr: MODE must be 0 or 1");
   end

   typedef enum logic [0:0] {StIdle, StXfer} state_e;

   state_e                  state_q, state_d;
   logic [NUM_IN-1:0]       pop_q, pop_d;
   logic [NUM_OUT-1:0]      push_q, push_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   // The last grant doubles as the round-robin pointer.
   logic [IdxW-1:0]         grant_q, grant_d;
   logic                    ptr_vld_q, ptr_vld_d;

   logic [DATA_WIDTH-1:0]     word [NUM_IN];
   logic [DEST_WIDTH-1:0]     dest [NUM_IN];
   logic [MAX_WORD_WIDTH-1:0] ext;
   logic [NUM_IN-1:0]         elig, gnt;
   logic [IdxW-1:0]           start, gnt_idx;
   logic                      any;

   // An input popped last cycle shows a stale head, so it sits out one cycle.
   always_comb begin
      ext = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         word[i]                = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
         ext                    = '0;
         ext[DATA_WIDTH-1:0]    = word[i];
         dest[i]                = DEST_WIDTH'(dest_field(ext, DEST_LSB, DEST_WIDTH));
         elig[i]                = !empty[i] && !almost_full[dest[i]] && !pop_q[i];
      end
   end

   // Until the first grant after reset, search starts at input 0 inclusive.
   assign start = ptr_vld_q ? IdxW'((32'(grant_q) + 32'd1) % NUM_IN) : '0;

   arbitro_pick #(
      .NumReq   (NUM_IN),
      .IdxWidth (IdxW)
   ) u_pick (
      .req       (elig),
      .start     (start),
      .prio_mode (MODE == MODE_PRIO),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .any       (any)
   );

   always_comb begin
      state_d   = state_q;
      pop_d     = any ? gnt : '0;
      push_d    = '0;
      data_d    = data_q;
      grant_d   = grant_q;
      ptr_vld_d = ptr_vld_q | any;
      for (int unsigned o = 0; o < NUM_OUT; o++) begin
         push_d[o] = any && (dest[gnt_idx] == DEST_WIDTH'(o));
      end
      if (any) begin
         data_d  = word[gnt_idx];
         grant_d = gnt_idx;
      end
      unique case (state_q)
         StIdle: if (any)  state_d = StXfer;
         StXfer: if (!any) state_d = StIdle;
         default:          state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         pop_q     <= '0;
         push_q    <= '0;
         data_q    <= '0;
         grant_q   <= '0;
         ptr_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pop_q     <= pop_d;
         push_q    <= push_d;
         data_q    <= data_d;
         grant_q   <= grant_d;
         ptr_vld_q <= ptr_vld_d;
      end
   end

   assign pop       = pop_q;
   assign push      = push_q;
   assign data_out  = data_q;
   assign grant_idx = grant_q;
   assign idle      = (state_q == StIdle);

`ifdef ARBITRO_PUSH_CNT_EN
   for (genvar o = 0; o < NUM_OUT; o++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)         cnt_q <= '0;
         else if (push_q[o]) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      assign push_cnt[o*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
   end
`else
   assign push_cnt = '0;
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: round-robin instance (a) and fixed-priority instance (b),
// each fed by a small show-ahead FIFO model.
module tb_arbitro_rr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [3:0]  empty_a, empty_b, af_a, af_b, pop_a, pop_b, push_a, push_b;
   logic [47:0] data_a, data_b;
   logic [11:0] dout_a, dout_b;
   logic [1:0]  gidx_a, gidx_b;
   logic        idle_a, idle_b;
   logic [31:0] cnt_a, cnt_b;

   logic [11:0] qa [4][$];
   logic [11:0] qb [4][$];

   int n_cmp = 0;
   int n_bad = 0;

   arbitro_rr #(.MODE(0)) dut_a (
      .clk(clk), .reset(reset), .empty(empty_a), .fifo_data(data_a), .almost_full(af_a),
      .pop(pop_a), .push(push_a), .data_out(dout_a), .grant_idx(gidx_a), .idle(idle_a),
      .push_cnt(cnt_a)
   );

   arbitro_rr #(.MODE(1)) dut_b (
      .clk(clk), .reset(reset), .empty(empty_b), .fifo_data(data_b), .almost_full(af_b),
      .pop(pop_b), .push(push_b), .data_out(dout_b), .grant_idx(gidx_b), .idle(idle_b),
      .push_cnt(cnt_b)
   );

   // FIFO model: consume popped heads mid-cycle; popped inputs are masked that cycle anyway.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (pop_a[i] && qa[i].size() > 0) void'(qa[i].pop_front());
         if (pop_b[i] && qb[i].size() > 0) void'(qb[i].pop_front());
         empty_a[i]         = (qa[i].size() == 0);
         empty_b[i]         = (qb[i].size() == 0);
         data_a[i*12 +: 12] = (qa[i].size() > 0) ? qa[i][0] : 12'h000;
         data_b[i*12 +: 12] = (qb[i].size() > 0) ? qb[i][0] : 12'h000;
      end
   end

   function automatic logic [11:0] mkw(input logic [1:0] d, input logic [7:0] tag);
      return {2'b00, d, tag};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain_a(input string name);
      bit done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         step();
         done = (qa[0].size() == 0 && qa[1].size() == 0 && qa[2].size() == 0 &&
                 qa[3].size() == 0 && idle_a === 1'b1);
      end
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s drain_a: got not-idle want idle within 60 cycles", name);
      end
   endtask

   task automatic wait_drain_b(input string name);
      bit done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         step();
         done = (qb[0].size() == 0 && qb[1].size() == 0 && qb[2].size() == 0 &&
                 qb[3].size() == 0 && idle_b === 1'b1);
      end
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s drain_b: got not-idle want idle within 60 cycles", name);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      qa[0].push_back(mkw(2'd0, 8'h00));
      qa[0].push_back(mkw(2'd2, 8'h01));
      qa[1].push_back(mkw(2'd1, 8'h10));
      qa[2].push_back(mkw(2'd2, 8'h20));
      qa[3].push_back(mkw(2'd3, 8'h30));
      step();
      step();
      n_cmp += 5;
      if (pop_a !== 4'b0000) begin n_bad++; $display("FAIL rst_pop got %b want 0000", pop_a); end
      if (push_a !== 4'b0000) begin n_bad++; $display("FAIL rst_push got %b want 0000", push_a); end
      if (dout_a !== 12'h000) begin n_bad++; $display("FAIL rst_data got %h want 000", dout_a); end
      if (gidx_a !== 2'd0) begin n_bad++; $display("FAIL rst_gidx got %0d want 0", gidx_a); end
      if (idle_a !== 1'b1) begin n_bad++; $display("FAIL rst_idle got %b want 1", idle_a); end
      reset = 1'b1;
      step();
      n_cmp += 4;
      if (pop_a !== 4'b0001) begin n_bad++; $display("FAIL first_pop got %b want 0001", pop_a); end
      if (push_a !== 4'b0001) begin n_bad++; $display("FAIL first_push got %b want 0001", push_a); end
      if (dout_a !== mkw(2'd0, 8'h00)) begin
         n_bad++; $display("FAIL first_data got %h want %h", dout_a, mkw(2'd0, 8'h00));
      end
      if (idle_a !== 1'b0) begin n_bad++; $display("FAIL first_idle got %b want 0", idle_a); end
   endtask

   task automatic test_round_robin();
      logic [3:0]  ep [5];
      logic [3:0]  eu [5];
      logic [11:0] ed [4];
      ep = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
      eu = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0000};
      ed = '{mkw(2'd1, 8'h10), mkw(2'd2, 8'h20), mkw(2'd3, 8'h30), mkw(2'd2, 8'h01)};
      for (int k = 0; k < 5; k++) begin
         step();
         n_cmp += 2;
         if (pop_a !== ep[k]) begin n_bad++; $display("FAIL rr_pop[%0d] got %b want %b", k, pop_a, ep[k]); end
         if (push_a !== eu[k]) begin n_bad++; $display("FAIL rr_push[%0d] got %b want %b", k, push_a, eu[k]); end
         if (k < 4) begin
            n_cmp += 2;
            if (dout_a !== ed[k]) begin n_bad++; $display("FAIL rr_data[%0d] got %h want %h", k, dout_a, ed[k]); end
            if (gidx_a !== 2'((k + 1) % 4)) begin
               n_bad++; $display("FAIL rr_gidx[%0d] got %0d want %0d", k, gidx_a, (k + 1) % 4);
            end
         end else begin
            n_cmp++;
            if (idle_a !== 1'b1) begin n_bad++; $display("FAIL rr_idle got %b want 1", idle_a); end
         end
      end
   endtask

   task automatic test_backpressure();
      // Pointer sits at input 0 here.
      af_a = 4'b1000;
      qa[2].push_back(mkw(2'd3, 8'h22));
      qa[1].push_back(mkw(2'd1, 8'h11));
      qa[3].push_back(mkw(2'd0, 8'h33));
      step();
      n_cmp += 2;
      if (pop_a !== 4'b0010) begin n_bad++; $display("FAIL bp_pop1 got %b want 0010", pop_a); end
      if (push_a !== 4'b0010) begin n_bad++; $display("FAIL bp_push1 got %b want 0010", push_a); end
      step();
      n_cmp += 2;
      if (pop_a !== 4'b1000) begin n_bad++; $display("FAIL bp_pop3 got %b want 1000", pop_a); end
      if (dout_a !== mkw(2'd0, 8'h33)) begin n_bad++; $display("FAIL bp_data3 got %h want %h", dout_a, mkw(2'd0, 8'h33)); end
      for (int k = 0; k < 2; k++) begin
         step();
         n_cmp += 2;
         if (pop_a !== 4'b0000) begin n_bad++; $display("FAIL bp_block_pop[%0d] got %b want 0000", k, pop_a); end
         if (idle_a !== 1'b1) begin n_bad++; $display("FAIL bp_block_idle[%0d] got %b want 1", k, idle_a); end
      end
      af_a = 4'b0000;
      step();
      n_cmp += 4;
      if (pop_a !== 4'b0100) begin n_bad++; $display("FAIL bp_rel_pop got %b want 0100", pop_a); end
      if (push_a !== 4'b1000) begin n_bad++; $display("FAIL bp_rel_push got %b want 1000", push_a); end
      if (dout_a !== mkw(2'd3, 8'h22)) begin n_bad++; $display("FAIL bp_rel_data got %h want %h", dout_a, mkw(2'd3, 8'h22)); end
      if (gidx_a !== 2'd2) begin n_bad++; $display("FAIL bp_rel_gidx got %0d want 2", gidx_a); end
      // Every destination almost full: data waits, nothing moves.
      af_a = 4'b1111;
      qa[0].push_back(mkw(2'd0, 8'h40));
      qa[1].push_back(mkw(2'd1, 8'h41));
      for (int k = 0; k < 2; k++) begin
         step();
         n_cmp += 2;
         if (pop_a !== 4'b0000) begin n_bad++; $display("FAIL allaf_pop[%0d] got %b want 0000", k, pop_a); end
         if (push_a !== 4'b0000) begin n_bad++; $display("FAIL allaf_push[%0d] got %b want 0000", k, push_a); end
      end
      af_a = 4'b0000;
      step();
      n_cmp++;
      if (pop_a !== 4'b0001) begin n_bad++; $display("FAIL allaf_wrap_pop got %b want 0001", pop_a); end
      step();
      n_cmp++;
      if (push_a !== 4'b0010) begin n_bad++; $display("FAIL allaf_next_push got %b want 0010", push_a); end
      wait_drain_a("backpressure");
   endtask

   task automatic test_same_dest();
      // Pointer at input 1: order 2, 0, 1, all into output 2 back to back.
      logic [3:0] ep [3];
      logic [7:0] et [3];
      ep = '{4'b0100, 4'b0001, 4'b0010};
      et = '{8'h52, 8'h50, 8'h51};
      qa[0].push_back(mkw(2'd2, 8'h50));
      qa[1].push_back(mkw(2'd2, 8'h51));
      qa[2].push_back(mkw(2'd2, 8'h52));
      for (int k = 0; k < 3; k++) begin
         step();
         n_cmp += 3;
         if (pop_a !== ep[k]) begin n_bad++; $display("FAIL same_pop[%0d] got %b want %b", k, pop_a, ep[k]); end
         if (push_a !== 4'b0100) begin n_bad++; $display("FAIL same_push[%0d] got %b want 0100", k, push_a); end
         if (dout_a !== mkw(2'd2, et[k])) begin
            n_bad++; $display("FAIL same_data[%0d] got %h want %h", k, dout_a, mkw(2'd2, et[k]));
         end
      end
      wait_drain_a("same_dest");
   endtask

   task automatic test_priority();
      for (int k = 0; k < 4; k++) qb[1].push_back(mkw(2'd2, 8'(8'h10 + k)));
      qb[3].push_back(mkw(2'd0, 8'h30));
      qb[3].push_back(mkw(2'd0, 8'h31));
      for (int k = 0; k < 6; k++) begin
         step();
         n_cmp += 2;
         if (k % 2 == 0) begin
            if (pop_b !== 4'b0010) begin n_bad++; $display("FAIL prio_pop[%0d] got %b want 0010", k, pop_b); end
            if (dout_b !== mkw(2'd2, 8'(8'h10 + k / 2))) begin
               n_bad++; $display("FAIL prio_data[%0d] got %h want %h", k, dout_b, mkw(2'd2, 8'(8'h10 + k / 2)));
            end
         end else begin
            if (pop_b !== 4'b1000) begin n_bad++; $display("FAIL prio_pop[%0d] got %b want 1000", k, pop_b); end
            if (push_b !== 4'b0001) begin n_bad++; $display("FAIL prio_push[%0d] got %b want 0001", k, push_b); end
         end
         while (qb[3].size() < 2) qb[3].push_back(mkw(2'd0, 8'h38));
      end
      wait_drain_b("priority");
   endtask

   task automatic test_reset_mid();
      // Pointer at input 1: first grant of the burst is input 2.
      for (int i = 0; i < 4; i++) qa[i].push_back(mkw(2'(i), 8'(8'h60 + i)));
      step();
      n_cmp++;
      if (pop_a !== 4'b0100) begin n_bad++; $display("FAIL mid_pop_before got %b want 0100", pop_a); end
      #2;
      reset = 1'b0;
      #1;
      n_cmp += 3;
      if (pop_a !== 4'b0000) begin n_bad++; $display("FAIL mid_pop_async got %b want 0000", pop_a); end
      if (push_a !== 4'b0000) begin n_bad++; $display("FAIL mid_push_async got %b want 0000", push_a); end
      if (idle_a !== 1'b1) begin n_bad++; $display("FAIL mid_idle_async got %b want 1", idle_a); end
      step();
      reset = 1'b1;
      step();
      n_cmp += 3;
      if (pop_a !== 4'b0001) begin n_bad++; $display("FAIL mid_restart_pop got %b want 0001", pop_a); end
      if (gidx_a !== 2'd0) begin n_bad++; $display("FAIL mid_restart_gidx got %0d want 0", gidx_a); end
      if (dout_a !== mkw(2'd0, 8'h60)) begin
         n_bad++; $display("FAIL mid_restart_data got %h want %h", dout_a, mkw(2'd0, 8'h60));
      end
      wait_drain_a("reset_mid");
   endtask

   task automatic test_push_cnt();
      int seen = 0;
      bit done = 0;
      logic [7:0] exp1;
`ifdef ARBITRO_PUSH_CNT_EN
      exp1 = 8'd44;
`else
      exp1 = 8'd0;
`endif
      reset = 1'b0;
      step();
      reset = 1'b1;
      for (int k = 0; k < 150; k++) begin
         qa[0].push_back(mkw(2'd1, 8'(k)));
         qa[1].push_back(mkw(2'd1, 8'(k)));
      end
      for (int k = 0; k < 400 && !done; k++) begin
         step();
         if (push_a[1] === 1'b1) seen++;
         done = (qa[0].size() == 0 && qa[1].size() == 0 && idle_a === 1'b1);
      end
      n_cmp += 4;
      if (!done) begin n_bad++; $display("FAIL cnt_drain got not-idle want idle within 400 cycles"); end
      if (seen != 300) begin n_bad++; $display("FAIL cnt_seen got %0d want 300", seen); end
      if (cnt_a[15:8] !== exp1) begin n_bad++; $display("FAIL cnt_out1 got %0d want %0d", cnt_a[15:8], exp1); end
      if (cnt_a[7:0] !== 8'd0) begin n_bad++; $display("FAIL cnt_out0 got %0d want 0", cnt_a[7:0]); end
   endtask

   initial begin
      reset   = 1'b0;
      af_a    = 4'b0000;
      af_b    = 4'b0000;
      empty_a = 4'b1111;
      empty_b = 4'b1111;
      data_a  = '0;
      data_b  = '0;
      test_reset();
      test_round_robin();
      test_backpressure();
      test_same_dest();
      test_priority();
      test_reset_mid();
      test_push_cnt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
